// File: rtl/cube_pkg.sv
// ============================================================================
// cube_pkg - shared types and geometry for the LED cube frame store
// Revision: 1.0
// ============================================================================
`default_nettype none

package cube_pkg;

  localparam int CUBE_LAYERS      = 8;
  localparam int CUBE_LATCHES     = 8;
  localparam int CUBE_FRAME_BYTES = 64;

  typedef logic [5:0] cube_addr_t;
  typedef logic [7:0] cube_row_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } fb_state_e;

endpackage

`default_nettype wire

// File: rtl/cube_frame_bank.sv
// ============================================================================
// cube_frame_bank - one frame register array, sync write port, comb read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module cube_frame_bank
  import cube_pkg::*;
#(
  parameter int        ADDR_W      = 6,
  parameter cube_row_t RST_PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  cube_row_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output cube_row_t         rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  cube_row_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_PATTERN;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/cube_frame_buffer.sv
// ============================================================================
// cube_frame_buffer - double-buffered 64-byte cube frame store, tear-free swap
// Revision: 1.0   Optional: CUBE_FB_STATS_EN adds starved-frame counter
// ============================================================================
`default_nettype none

module cube_frame_buffer
  import cube_pkg::*;
#(
  parameter int        ADDR_W      = 6,
  parameter cube_row_t RST_PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_done,
`ifdef CUBE_FB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       repeat_cnt,
`endif
  output logic              swapped,
  output logic              resync
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  fb_state_e         state, state_nxt;
  logic              disp_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] waddr;
  logic              accept;
  logic              last_byte;
  logic              swap;
  cube_row_t         bank_rdata [2];
  logic [1:0]        bank_we;

  assign in_ready  = (state == FILL) && !rst;
  assign accept    = in_valid && in_ready;
  assign waddr     = in_sof ? '0 : wr_ptr;
  assign last_byte = accept && (waddr == LAST_ADDR);
  assign swap      = (state == FULL) && frame_done;

  // Bank b is the write bank whenever it is not the display bank.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);

    assign bank_we[b] = accept && (disp_bank != SEL);

    cube_frame_bank #(
      .ADDR_W      (ADDR_W),
      .RST_PATTERN (RST_PATTERN)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .waddr (waddr),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  assign rd_data = bank_rdata[disp_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_byte) state_nxt = FULL;
      FULL:    if (frame_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bank <= 1'b0;
      wr_ptr    <= '0;
      swapped   <= 1'b0;
      resync    <= 1'b0;
    end else begin
      swapped <= swap;
      // A SOF arriving with a non-zero pointer abandons the partial frame.
      resync  <= accept && in_sof && (wr_ptr != '0);
      if (swap) begin
        disp_bank <= ~disp_bank;
      end
      if (accept) begin
        wr_ptr <= last_byte ? '0 : waddr + ADDR_W'(1);
      end
    end
  end

`ifdef CUBE_FB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      repeat_cnt <= 16'h0000;
    end else if (frame_done && (state == FILL) && (repeat_cnt != 16'hFFFF)) begin
      repeat_cnt <= repeat_cnt + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cube_frame_buffer.sv
// ============================================================================
// tb_cube_frame_buffer - directed, table-driven check of cube_frame_buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cube_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_ready;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       swapped;
  logic       resync;
`ifdef CUBE_FB_STATS_EN
  logic        stats_clr;
  logic [15:0] repeat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cube_frame_buffer #(
    .ADDR_W      (6),
    .RST_PATTERN (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
`ifdef CUBE_FB_STATS_EN
    .stats_clr  (stats_clr),
    .repeat_cnt (repeat_cnt),
`endif
    .swapped    (swapped),
    .resync     (resync)
  );

  typedef struct {
    int         phase;
    logic [5:0] addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic check_phase(input int p);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].phase == p) begin
        rd_addr = tbl[i].addr;
        #1;
        check($sformatf("phase%0d_rd_data[%h]", p, tbl[i].addr), 16'(rd_data), 16'(tbl[i].exp_data));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 6'h00, 8'h00};
    tbl[1]  = '{1, 6'h01, 8'h01};
    tbl[2]  = '{1, 6'h2A, 8'h2A};
    tbl[3]  = '{1, 6'h3F, 8'h3F};
    tbl[4]  = '{1, 6'h10, 8'h10};
    tbl[5]  = '{2, 6'h00, 8'hAA};
    tbl[6]  = '{2, 6'h01, 8'h80};
    tbl[7]  = '{2, 6'h09, 8'h88};
    tbl[8]  = '{2, 6'h3F, 8'hBE};
    tbl[9]  = '{3, 6'h00, 8'h40};
    tbl[10] = '{3, 6'h3F, 8'h7F};
    tbl[11] = '{3, 6'h20, 8'h60};
    tbl[12] = '{4, 6'h00, 8'h60};
    tbl[13] = '{4, 6'h1E, 8'h7E};
    tbl[14] = '{4, 6'h3F, 8'h9F};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_sof     = 1'b0;
    rd_addr    = 6'h00;
    frame_done = 1'b0;
`ifdef CUBE_FB_STATS_EN
    stats_clr  = 1'b0;
`endif

    // Reset state
    step(); step(); step();
    check("in_ready_during_rst", 16'(in_ready), 16'h0);
    check("swapped_reset", 16'(swapped), 16'h0);
    check("resync_reset", 16'(resync), 16'h0);
`ifdef CUBE_FB_STATS_EN
    check("repeat_cnt_reset", repeat_cnt, 16'h0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 16'(in_ready), 16'h1);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      check($sformatf("reset_sweep[%0d]", a), 16'(rd_data), 16'h00);
    end

    // Full frame 00..3F, held until frame_done
    step();
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 0);
    check("in_ready_after_64", 16'(in_ready), 16'h0);
    rd_addr = 6'h2A;
    #1;
    check("rd_unchanged_before_swap", 16'(rd_data), 16'h00);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    in_valid = 1'b0;
    check("in_ready_while_full", 16'(in_ready), 16'h0);
    pulse_frame_done();
    check("swapped_after_fd", 16'(swapped), 16'h1);
    check("in_ready_after_swap", 16'(in_ready), 16'h1);
    check_phase(1);
    step();
    check("swapped_one_cycle", 16'(swapped), 16'h0);

    // Partial frame abandoned by SOF
    for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i), 1'b0);
    check("no_resync_partial", 16'(resync), 16'h0);
    send_byte(8'hAA, 1'b1);
    check("resync_pulse", 16'(resync), 16'h1);
    send_byte(8'h80, 1'b0);
    check("resync_one_cycle", 16'(resync), 16'h0);
    for (int i = 1; i < 63; i++) send_byte(8'h80 + 8'(i), 1'b0);
    check("in_ready_after_resync_frame", 16'(in_ready), 16'h0);
    rd_addr = 6'h00;
    #1;
    check("write_bank_isolated", 16'(rd_data), 16'h00);
    pulse_frame_done();
    check("swapped_resync_frame", 16'(swapped), 16'h1);
    check_phase(2);

    // Last byte coincides with frame_done: swap deferred
    for (int i = 0; i < 63; i++) send_byte(8'h40 + 8'(i), i == 0);
    frame_done = 1'b1;
    send_byte(8'h7F, 1'b0);
    frame_done = 1'b0;
    check("no_swap_same_cycle", 16'(swapped), 16'h0);
    check("full_after_late_byte", 16'(in_ready), 16'h0);
    rd_addr = 6'h3F;
    #1;
    check("old_frame_still_shown", 16'(rd_data), 16'hBE);
    step();
    check("no_swap_deferred", 16'(swapped), 16'h0);
    pulse_frame_done();
    check("swap_next_fd", 16'(swapped), 16'h1);
    check_phase(3);

    // Starved frames repeat the display
`ifdef CUBE_FB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("repeat_cnt_cleared", repeat_cnt, 16'h0);
`endif
    for (int k = 0; k < 3; k++) begin
      pulse_frame_done();
      check($sformatf("starved_no_swap%0d", k), 16'(swapped), 16'h0);
      step();
    end
    rd_addr = 6'h00;
    #1;
    check("starved_repeat_frame", 16'(rd_data), 16'h40);
`ifdef CUBE_FB_STATS_EN
    check("repeat_cnt_3", repeat_cnt, 16'h3);
    stats_clr  = 1'b1;
    frame_done = 1'b1;
    step();
    stats_clr  = 1'b0;
    frame_done = 1'b0;
    check("clear_wins_over_inc", repeat_cnt, 16'h0);
`endif

    // Reset mid-fill discards everything
    for (int i = 0; i < 30; i++) send_byte(8'hD0 + 8'(i), i == 0);
    rst = 1'b1;
    #1;
    check("in_ready_low_in_rst", 16'(in_ready), 16'h0);
    step();
    rd_addr = 6'h00;
    #1;
    check("rd_data_after_rst", 16'(rd_data), 16'h00);
    check("swapped_after_rst", 16'(swapped), 16'h0);
    check("resync_after_rst", 16'(resync), 16'h0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst2", 16'(in_ready), 16'h1);
    step();
    for (int i = 0; i < 64; i++) send_byte(8'h60 + 8'(i), 1'b0);
    check("full_after_reload", 16'(in_ready), 16'h0);
    pulse_frame_done();
    check("swap_after_reload", 16'(swapped), 16'h1);
    check_phase(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
